// File: rtl/uart_pkg.sv
// Shared definitions for the Dataflow serial link (receiver and transmitter).
package uart_pkg;

  // Receiver frame states, in the order a frame is received.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Encoding of the parity_type_even_odd input. The transmitter uses the same encoding.
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_bit_timer.sv
// Bit-phase counter for the serial receiver.
// Produces the mid-bit sample strobe and the end-of-bit wrap strobe.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic sample_stb,
  output logic wrap_stb
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] MID_PH   = PW'(CLKS_PER_BIT / 2);
  localparam logic [PW-1:0] LAST_PH  = PW'(CLKS_PER_BIT - 1);
  // The start-detect edge is already phase 0 of the start bit, so the edge after it is phase 1.
  localparam logic [PW-1:0] FIRST_PH = (CLKS_PER_BIT > 1) ? PW'(1) : PW'(0);

  logic [PW-1:0] phase_reg;

  // Phase advances once per clock while a frame is in progress and wraps at the end of each bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= '0;
    end else if (restart) begin
      phase_reg <= FIRST_PH;
    end else if (run) begin
      phase_reg <= (phase_reg == LAST_PH) ? '0 : phase_reg + PW'(1);
    end
  end

  assign sample_stb = run && (phase_reg == MID_PH);
  assign wrap_stb   = run && (phase_reg == LAST_PH);

endmodule : uart_bit_timer

// File: rtl/dataflow_rx.sv
// Serial receiver for the Dataflow_Tx line: start, n data bits LSB-first,
// optional parity, stop. Delivers the word with a one-cycle valid strobe.
module dataflow_rx
  import uart_pkg::*;
#(
  parameter int n            = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Rx,
  input  logic         parity_check,
  input  logic         parity_type_even_odd,
  output logic [n-1:0] D_out,
  output logic         valid,
  output logic         parity_error,
  output logic         frame_error,
  output logic         busy
);

  localparam int IDX_W = (n > 1) ? $clog2(n) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(n - 1);
  // With one clock per bit the detect edge doubles as the start-bit confirmation.
  localparam bit ONE_CLK = (CLKS_PER_BIT == 1);

  rx_state_t      state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [n-1:0]   shift_reg;
  logic           par_en_reg;
  logic           par_odd_reg;
  logic           perr_reg;
  logic           armed_reg;
  logic [n-1:0]   d_out_reg;
  logic           valid_reg;
  logic           parity_error_reg;
  logic           frame_error_reg;
  logic           busy_reg;

  logic timer_restart;
  logic timer_run;
  logic sample_stb;
  logic wrap_stb;

  assign timer_restart = (state_reg == IDLE) && armed_reg && !Rx;
  assign timer_run     = (state_reg != IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (timer_restart),
    .run       (timer_run),
    .sample_stb(sample_stb),
    .wrap_stb  (wrap_stb)
  );

  // Frame FSM: detection, per-bit sampling, parity evaluation and output update at the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      shift_reg        <= '0;
      par_en_reg       <= 1'b0;
      par_odd_reg      <= 1'b0;
      perr_reg         <= 1'b0;
      armed_reg        <= 1'b1;
      d_out_reg        <= '0;
      valid_reg        <= 1'b0;
      parity_error_reg <= 1'b0;
      frame_error_reg  <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!armed_reg) begin
            // After a framing error wait for the line to go high before looking for a start.
            if (Rx) armed_reg <= 1'b1;
          end else if (!Rx) begin
            busy_reg    <= 1'b1;
            par_en_reg  <= parity_check;
            par_odd_reg <= parity_type_even_odd;
            perr_reg    <= 1'b0;
            idx_reg     <= '0;
            state_reg   <= ONE_CLK ? DATA : START;
          end
        end
        START: begin
          if (sample_stb && Rx) begin
            // Line was high again at mid-bit: a glitch, not a start bit.
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (wrap_stb) begin
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (sample_stb) shift_reg[idx_reg] <= Rx;
          if (wrap_stb) begin
            if (idx_reg == IDX_LAST) begin
              idx_reg   <= '0;
              state_reg <= par_en_reg ? PARITY : STOP;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        PARITY: begin
          if (sample_stb) perr_reg <= (Rx != ((^shift_reg) ^ par_odd_reg));
          if (wrap_stb) state_reg <= STOP;
        end
        STOP: begin
          // Finish at the stop sample so a start bit right after it is not missed.
          if (sample_stb) begin
            d_out_reg        <= shift_reg;
            parity_error_reg <= par_en_reg & perr_reg;
            frame_error_reg  <= ~Rx;
            valid_reg        <= 1'b1;
            busy_reg         <= 1'b0;
            if (!Rx) armed_reg <= 1'b0;
            state_reg        <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign D_out        = d_out_reg;
  assign valid        = valid_reg;
  assign parity_error = parity_error_reg;
  assign frame_error  = frame_error_reg;
  assign busy         = busy_reg;

endmodule : dataflow_rx
